// File: rtl/reg_rename_file.sv
// -----------------------------------------------------------------------------
// reg_rename_file
//
// Architectural register file with per-register rename tags. It sits between
// the instruction queue and the reorder buffer (ROB).
//
//   Dispatch side : takes one decoded instruction per cycle. Each source index
//                   is resolved to either a ready value or the tag (pc) of the
//                   in-flight producer. The destination is renamed to the
//                   instruction's pc. The result is a registered packet for
//                   the ROB.
//   Commit side   : the in-order commit stream writes values. It releases a
//                   register's busy bit only when the committing pc is still
//                   that register's current tag.
//   Flush side    : an exception clears every busy bit and discards both the
//                   held packet and the incoming instruction.
//
// Optional build feature (macro REG_PERF_COUNTER_EN):
//   When defined, two 32-bit debug counters are added:
//     dispatch_count_to_debug - packets consumed by the ROB
//     commit_count_to_debug   - is_finish_from_rob pulses
//   Both wrap, reset to zero, and are not cleared by an exception.
//   When undefined, the ports and their logic do not exist.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   is_empty_from_instr_queue        0 = instruction valid this cycle
//   op/rs1/rs2/rd/imm/pc_from_instr_queue   decoded instruction fields
//   is_stall_from_rob                ROB cannot take the presented packet
//   is_finish_from_rob               commit valid
//   commit_rd/data/pc_from_rob       commit destination, value and tag
//   is_exception_from_rob            flush speculative rename state
//   is_stall_to_instr_queue          hold instruction (combinational)
//   is_empty_to_rob                  0 = dispatch packet valid
//   op/v1/v2/q1/q2/r1/r2/imm/rd/pc_to_rob   registered dispatch packet
// -----------------------------------------------------------------------------
module reg_rename_file #(
  parameter int DataWidth = 32,
  parameter int PcWidth   = 32,
  parameter int OpWidth   = 6,
  parameter int RegCount  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  // instruction queue
  input  logic                 is_empty_from_instr_queue,
  input  logic [OpWidth-1:0]   op_from_instr_queue,
  input  logic [4:0]           rs1_from_instr_queue,
  input  logic [4:0]           rs2_from_instr_queue,
  input  logic [4:0]           rd_from_instr_queue,
  input  logic [DataWidth-1:0] imm_from_instr_queue,
  input  logic [PcWidth-1:0]   pc_from_instr_queue,
  // reorder buffer
  input  logic                 is_stall_from_rob,
  input  logic                 is_finish_from_rob,
  input  logic [4:0]           commit_rd_from_rob,
  input  logic [DataWidth-1:0] commit_data_from_rob,
  input  logic [PcWidth-1:0]   commit_pc_from_rob,
  input  logic                 is_exception_from_rob,
  // outputs
  output logic                 is_stall_to_instr_queue,
  output logic                 is_empty_to_rob,
  output logic [OpWidth-1:0]   op_to_rob,
  output logic [DataWidth-1:0] v1_to_rob,
  output logic [DataWidth-1:0] v2_to_rob,
  output logic [PcWidth-1:0]   q1_to_rob,
  output logic [PcWidth-1:0]   q2_to_rob,
  output logic                 r1_to_rob,
  output logic                 r2_to_rob,
  output logic [DataWidth-1:0] imm_to_rob,
  output logic [4:0]           rd_to_rob,
  output logic [PcWidth-1:0]   pc_to_rob
`ifdef REG_PERF_COUNTER_EN
  ,
  output logic [31:0]          dispatch_count_to_debug,
  output logic [31:0]          commit_count_to_debug
`endif
);

  localparam int IdxWidth = 5;

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0] r_value [RegCount];
  logic [PcWidth-1:0]   r_tag   [RegCount];
  logic [RegCount-1:0]  r_busy;

  // Registered dispatch packet
  logic                 r_empty;
  logic [OpWidth-1:0]   r_op;
  logic [DataWidth-1:0] r_v1;
  logic [DataWidth-1:0] r_v2;
  logic [PcWidth-1:0]   r_q1;
  logic [PcWidth-1:0]   r_q2;
  logic                 r_r1;
  logic                 r_r2;
  logic [DataWidth-1:0] r_imm;
  logic [4:0]           r_rd;
  logic [PcWidth-1:0]   r_pc;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_stall;
  logic w_accept;

  // Only a valid packet can be stalled; an empty output slot always accepts.
  assign w_stall  = is_stall_from_rob & ~r_empty;
  assign w_accept = ~is_empty_from_instr_queue & ~w_stall & ~is_exception_from_rob;

  assign is_stall_to_instr_queue = w_stall;

  // ---------------------------------------------------------------------------
  // Per-register commit / rename decode and next busy state
  // ---------------------------------------------------------------------------
  logic [RegCount-1:0] w_commit_sel;   // commit writes this register's value
  logic [RegCount-1:0] w_commit_clear; // commit is from the current producer
  logic [RegCount-1:0] w_rename_sel;   // accepted instruction renames this register
  logic [RegCount-1:0] w_busy_next;

  for (genvar gi = 0; gi < RegCount; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      // x0 is hardwired: never written, never busy.
      assign w_commit_sel[gi]   = 1'b0;
      assign w_commit_clear[gi] = 1'b0;
      assign w_rename_sel[gi]   = 1'b0;
      assign w_busy_next[gi]    = 1'b0;
    end else begin : g_arch
      assign w_commit_sel[gi]   = is_finish_from_rob &&
                                  (commit_rd_from_rob == IdxWidth'(gi));
      // A younger rename has replaced the tag, so an older commit must not
      // release the register.
      assign w_commit_clear[gi] = w_commit_sel[gi] &&
                                  (r_tag[gi] == commit_pc_from_rob);
      assign w_rename_sel[gi]   = w_accept &&
                                  (rd_from_instr_queue == IdxWidth'(gi));
      // Priority: flush, then rename (wins over a same-cycle commit), then
      // the release from a matching commit.
      assign w_busy_next[gi]    = is_exception_from_rob ? 1'b0 :
                                  w_rename_sel[gi]      ? 1'b1 :
                                  w_commit_clear[gi]    ? 1'b0 :
                                                          r_busy[gi];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RegCount; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 1; i < RegCount; i++) begin
        // The value is written even during a flush or a same-cycle rename.
        if (w_commit_sel[i]) begin
          r_value[i] <= commit_data_from_rob;
        end
        if (w_rename_sel[i]) begin
          r_tag[i] <= pc_from_instr_queue;
        end
      end
      r_busy <= w_busy_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand resolution for rs1 (g_op[0]) and rs2 (g_op[1])
  // Sources are read from the pre-rename state, so an instruction that reads
  // its own rd sees the previous producer.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    logic [IdxWidth-1:0]  w_rs;
    logic [DataWidth-1:0] w_v;
    logic [PcWidth-1:0]   w_q;
    logic                 w_r;

    assign w_rs = (gi == 0) ? rs1_from_instr_queue : rs2_from_instr_queue;

    always_comb begin
      w_v = '0;
      w_q = '0;
      w_r = 1'b1;
      if (w_rs == '0) begin
        // x0: constant zero, always ready
        w_v = '0;
      end else if (r_busy[w_rs] && is_finish_from_rob &&
                   (commit_pc_from_rob == r_tag[w_rs])) begin
        // The producer commits this very cycle: forward its result.
        w_v = commit_data_from_rob;
      end else if (r_busy[w_rs]) begin
        w_q = r_tag[w_rs];
        w_r = 1'b0;
      end else begin
        w_v = r_value[w_rs];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatch packet register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_empty <= 1'b1;
      r_op    <= '0;
      r_v1    <= '0;
      r_v2    <= '0;
      r_q1    <= '0;
      r_q2    <= '0;
      r_r1    <= 1'b1;
      r_r2    <= 1'b1;
      r_imm   <= '0;
      r_rd    <= '0;
      r_pc    <= '0;
    end else if (is_exception_from_rob) begin
      // Flush: drop the held packet; the incoming one is not accepted.
      r_empty <= 1'b1;
    end else if (w_stall) begin
      // ROB is not ready: keep presenting the same packet unchanged.
      r_empty <= r_empty;
    end else if (w_accept) begin
      r_empty <= 1'b0;
      r_op    <= op_from_instr_queue;
      r_v1    <= g_op[0].w_v;
      r_v2    <= g_op[1].w_v;
      r_q1    <= g_op[0].w_q;
      r_q2    <= g_op[1].w_q;
      r_r1    <= g_op[0].w_r;
      r_r2    <= g_op[1].w_r;
      r_imm   <= imm_from_instr_queue;
      r_rd    <= rd_from_instr_queue;
      r_pc    <= pc_from_instr_queue;
    end else begin
      r_empty <= 1'b1;
    end
  end

  assign is_empty_to_rob = r_empty;
  assign op_to_rob       = r_op;
  assign v1_to_rob       = r_v1;
  assign v2_to_rob       = r_v2;
  assign q1_to_rob       = r_q1;
  assign q2_to_rob       = r_q2;
  assign r1_to_rob       = r_r1;
  assign r2_to_rob       = r_r2;
  assign imm_to_rob      = r_imm;
  assign rd_to_rob       = r_rd;
  assign pc_to_rob       = r_pc;

`ifdef REG_PERF_COUNTER_EN
  // ---------------------------------------------------------------------------
  // Debug counters (survive a flush; only rst clears them)
  // ---------------------------------------------------------------------------
  logic [31:0] r_dispatch_count;
  logic [31:0] r_commit_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dispatch_count <= '0;
      r_commit_count   <= '0;
    end else begin
      if (~r_empty && ~is_stall_from_rob) begin
        r_dispatch_count <= r_dispatch_count + 32'd1;
      end
      if (is_finish_from_rob) begin
        r_commit_count <= r_commit_count + 32'd1;
      end
    end
  end

  assign dispatch_count_to_debug = r_dispatch_count;
  assign commit_count_to_debug   = r_commit_count;
`endif

endmodule
